alu_operand_sequencer: RTL and testbench



---
 rtl/alu_operand_sequencer.sv | 144 ++++++++++++++
 tb/tb_alu_operand_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_sequencer.sv
// Collects opcode, a and b over three debounced ENTER presses, pulses execute, captures f.
// Press-to-strobe is 2 + DEBOUNCE_CYCLES cycles; execute and capture follow in the next two cycles.

module alu_seq_debounce #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int CNT_W           = 18
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_i,
   output logic press_o
);
   logic [1:0]       sync_q;
   logic [1:0]       fill_q;
   logic             level_q;
   logic             armed_q;
   logic             press_q;
   logic [CNT_W-1:0] cnt_q;

   assign press_o = press_q;

   // Strobes stay disarmed until a released level is seen, so a button held through reset is ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= 2'b00;
         fill_q  <= 2'b00;
         level_q <= 1'b0;
         armed_q <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync_q  <= {sync_q[0], btn_i};
         fill_q  <= {fill_q[0], 1'b1};
         press_q <= 1'b0;
         if (fill_q[1] && !sync_q[1] && !level_q)
            armed_q <= 1'b1;
         if (sync_q[1] == level_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level_q <= sync_q[1];
            cnt_q   <= '0;
            press_q <= sync_q[1] & armed_q;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end
endmodule

module alu_operand_sequencer #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int CNT_W           = 18
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] sw,
   input  logic       btn_enter,
   input  logic       btn_clear,
   input  logic [5:0] f,
   output logic [2:0] opcode,
   output logic [2:0] a,
   output logic [2:0] b,
   output logic       execute,
   output logic [5:0] result,
   output logic       result_valid,
   output logic [2:0] state
);
   typedef enum logic [2:0] {
      S_OP   = 3'd0,
      S_A    = 3'd1,
      S_B    = 3'd2,
      S_EXEC = 3'd3,
      S_CAPT = 3'd4
   } state_t;

   state_t     state_q;
   logic [2:0] opcode_q, a_q, b_q;
   logic       execute_q;
   logic [5:0] result_q;
   logic       result_valid_q;
   logic       enter_stb;
   logic       clear_stb;

   alu_seq_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_enter (
      .clk(clk), .rst_n(rst_n), .btn_i(btn_enter), .press_o(enter_stb));

   alu_seq_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_clear (
      .clk(clk), .rst_n(rst_n), .btn_i(btn_clear), .press_o(clear_stb));

   assign opcode       = opcode_q;
   assign a            = a_q;
   assign b            = b_q;
   assign execute      = execute_q;
   assign result       = result_q;
   assign result_valid = result_valid_q;
   assign state        = state_q;

   // Clear outranks enter; execute is raised on entry to S_EXEC so it spans exactly that state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_OP;
         opcode_q       <= 3'd0;
         a_q            <= 3'd0;
         b_q            <= 3'd0;
         execute_q      <= 1'b0;
         result_q       <= 6'd0;
         result_valid_q <= 1'b0;
      end else begin
         execute_q <= 1'b0;
         if (clear_stb) begin
            state_q        <= S_OP;
            opcode_q       <= 3'd0;
            a_q            <= 3'd0;
            b_q            <= 3'd0;
            result_q       <= 6'd0;
            result_valid_q <= 1'b0;
         end else begin
            case (state_q)
               S_OP: if (enter_stb) begin
                  opcode_q       <= sw;
                  result_valid_q <= 1'b0;
                  state_q        <= S_A;
               end
               S_A: if (enter_stb) begin
                  a_q     <= sw;
                  state_q <= S_B;
               end
               S_B: if (enter_stb) begin
                  b_q       <= sw;
                  execute_q <= 1'b1;
                  state_q   <= S_EXEC;
               end
               S_EXEC: state_q <= S_CAPT;
               S_CAPT: begin
                  result_q       <= f;
                  result_valid_q <= 1'b1;
                  state_q        <= S_OP;
               end
               default: state_q <= S_OP;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Scoreboard bench for alu_operand_sequencer with a short debounce window.

module tb_alu_operand_sequencer;
   localparam int DB = 4;

   typedef struct packed {
      logic [2:0] op;
      logic [2:0] a;
      logic [2:0] b;
      logic [5:0] f;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] sw = 3'd0;
   logic       btn_enter = 1'b0;
   logic       btn_clear = 1'b0;
   logic [5:0] f;
   logic [2:0] opcode, a, b, state;
   logic       execute, result_valid;
   logic [5:0] result;

   int   n_chk = 0;
   int   n_pass = 0;
   int   exec_cnt = 0;
   exp_t sb[$];

   alu_operand_sequencer #(.DEBOUNCE_CYCLES(DB), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .sw(sw), .btn_enter(btn_enter), .btn_clear(btn_clear),
      .f(f), .opcode(opcode), .a(a), .b(b), .execute(execute), .result(result),
      .result_valid(result_valid), .state(state));

   always #5 clk = ~clk;

   function automatic logic [5:0] alu_f(input logic [2:0] op, input logic [2:0] x, input logic [2:0] y);
      case (op)
         3'b001:  alu_f = {3'b000, x} + {3'b000, y};
         3'b010:  alu_f = {3'b000, x} - {3'b000, y};
         default: alu_f = {x, y};
      endcase
   endfunction

   assign f = alu_f(opcode, a, b);

   always @(negedge clk) if (execute === 1'b1) exec_cnt++;

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic press(input bit clr, input logic [2:0] v, output bit moved);
      logic [2:0] s0;
      s0 = state;
      sw = v;
      moved = 1'b0;
      if (clr) btn_clear = 1'b1; else btn_enter = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (state !== s0) begin
            moved = 1'b1;
            break;
         end
      end
      repeat (3) tick();
      btn_enter = 1'b0;
      btn_clear = 1'b0;
      repeat (DB + 6) tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      n_chk++;
      if ({opcode, a, b, execute, result, result_valid} !== 16'd0)
         $display("FAIL reset_outputs: got %h want 0", {opcode, a, b, execute, result, result_valid});
      else n_pass++;
      n_chk++;
      if (state !== 3'd0) $display("FAIL reset_state: got %0d want 0", state); else n_pass++;
      rst_n = 1'b1;
      repeat (6) tick();
   endtask

   task automatic test_basic();
      bit   mv, seen;
      int   e0;
      exp_t e;
      sb.push_back('{op: 3'b001, a: 3'b010, b: 3'b011, f: alu_f(3'b001, 3'b010, 3'b011)});
      press(1'b0, 3'b001, mv);
      n_chk++;
      if (state !== 3'd1 || opcode !== 3'b001) $display("FAIL basic_opcode: got st=%0d op=%b want st=1 op=001", state, opcode); else n_pass++;
      press(1'b0, 3'b010, mv);
      n_chk++;
      if (state !== 3'd2 || a !== 3'b010) $display("FAIL basic_a: got st=%0d a=%b want st=2 a=010", state, a); else n_pass++;
      e0 = exec_cnt;
      sw = 3'b011;
      btn_enter = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (execute === 1'b1) begin seen = 1'b1; break; end
      end
      e = sb.pop_front();
      n_chk++;
      if (!seen || state !== 3'd3 || {opcode, a, b} !== {e.op, e.a, e.b})
         $display("FAIL basic_exec: got seen=%0d st=%0d ops=%h want seen=1 st=3 ops=%h", seen, state, {opcode, a, b}, {e.op, e.a, e.b});
      else n_pass++;
      tick();
      n_chk++;
      if (execute !== 1'b0 || state !== 3'd4) $display("FAIL basic_capt: got ex=%b st=%0d want ex=0 st=4", execute, state); else n_pass++;
      tick();
      n_chk++;
      if (result !== e.f || result_valid !== 1'b1 || state !== 3'd0)
         $display("FAIL basic_result: got r=%b v=%b st=%0d want r=%b v=1 st=0", result, result_valid, state, e.f);
      else n_pass++;
      n_chk++;
      if (exec_cnt - e0 !== 1) $display("FAIL basic_pulses: got %0d want 1", exec_cnt - e0); else n_pass++;
      btn_enter = 1'b0;
      repeat (DB + 6) tick();
   endtask

   task automatic test_bounce();
      bit mv;
      sw = 3'b100;
      for (int i = 0; i < 10; i++) begin
         btn_enter = ~btn_enter;
         repeat (2) tick();
      end
      n_chk++;
      if (state !== 3'd0) $display("FAIL bounce_glitch: got st=%0d want 0", state); else n_pass++;
      btn_enter = 1'b1;
      repeat (10) tick();
      n_chk++;
      if (state !== 3'd1 || opcode !== 3'b100) $display("FAIL bounce_one_step: got st=%0d op=%b want st=1 op=100", state, opcode); else n_pass++;
      repeat (10) tick();
      n_chk++;
      if (state !== 3'd1) $display("FAIL bounce_held: got st=%0d want 1", state); else n_pass++;
      btn_enter = 1'b0;
      repeat (DB + 6) tick();
      press(1'b1, 3'b000, mv);
      n_chk++;
      if (state !== 3'd0) $display("FAIL bounce_clear: got st=%0d want 0", state); else n_pass++;
   endtask

   task automatic test_clear_mid_entry();
      bit mv;
      int e0;
      press(1'b0, 3'b110, mv);
      press(1'b0, 3'b101, mv);
      n_chk++;
      if (state !== 3'd2 || {opcode, a} !== 6'b110101) $display("FAIL clr_setup: got st=%0d op/a=%b want st=2 110101", state, {opcode, a}); else n_pass++;
      e0 = exec_cnt;
      press(1'b1, 3'b000, mv);
      n_chk++;
      if (state !== 3'd0 || {opcode, a, b} !== 9'd0) $display("FAIL clr_regs: got st=%0d ops=%h want st=0 ops=0", state, {opcode, a, b}); else n_pass++;
      n_chk++;
      if (result !== 6'd0 || result_valid !== 1'b0) $display("FAIL clr_result: got r=%b v=%b want 0 0", result, result_valid); else n_pass++;
      n_chk++;
      if (exec_cnt !== e0) $display("FAIL clr_no_exec: got %0d pulses want 0", exec_cnt - e0); else n_pass++;
   endtask

   task automatic test_clear_enter_same();
      bit mv;
      int e0;
      press(1'b0, 3'b001, mv);
      press(1'b0, 3'b010, mv);
      e0 = exec_cnt;
      sw = 3'b111;
      btn_enter = 1'b1;
      btn_clear = 1'b1;
      repeat (15) tick();
      n_chk++;
      if (state !== 3'd0 || b !== 3'd0 || opcode !== 3'd0) $display("FAIL both_state: got st=%0d b=%b op=%b want 0 0 0", state, b, opcode); else n_pass++;
      n_chk++;
      if (exec_cnt !== e0) $display("FAIL both_no_exec: got %0d pulses want 0", exec_cnt - e0); else n_pass++;
      btn_enter = 1'b0;
      btn_clear = 1'b0;
      repeat (DB + 6) tick();
   endtask

   task automatic test_ignore_enter();
      bit   mv, seen;
      int   e0;
      exp_t e;
      sb.push_back('{op: 3'b010, a: 3'b110, b: 3'b011, f: alu_f(3'b010, 3'b110, 3'b011)});
      press(1'b0, 3'b010, mv);
      press(1'b0, 3'b110, mv);
      e0 = exec_cnt;
      sw = 3'b011;
      btn_enter = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (execute === 1'b1) begin seen = 1'b1; break; end
      end
      force dut.enter_stb = 1'b1;
      tick();
      n_chk++;
      if (state !== 3'd4 || execute !== 1'b0) $display("FAIL ign_capt: got st=%0d ex=%b want st=4 ex=0", state, execute); else n_pass++;
      tick();
      release dut.enter_stb;
      e = sb.pop_front();
      n_chk++;
      if (!seen || state !== 3'd0 || opcode !== e.op || result !== e.f || result_valid !== 1'b1)
         $display("FAIL ign_result: got seen=%0d st=%0d op=%b r=%b v=%b want 1 0 %b %b 1", seen, state, opcode, result, result_valid, e.op, e.f);
      else n_pass++;
      n_chk++;
      if (exec_cnt - e0 !== 1) $display("FAIL ign_pulses: got %0d want 1", exec_cnt - e0); else n_pass++;
      btn_enter = 1'b0;
      repeat (DB + 6) tick();
      press(1'b0, 3'b111, mv);
      n_chk++;
      if (state !== 3'd1 || opcode !== 3'b111 || result_valid !== 1'b0)
         $display("FAIL ign_next_op: got st=%0d op=%b v=%b want 1 111 0", state, opcode, result_valid);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      bit mv, seen;
      press(1'b0, 3'b001, mv);
      sw = 3'b001;
      btn_enter = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 25; i++) begin
         tick();
         if (state === 3'd4) begin seen = 1'b1; break; end
      end
      n_chk++;
      if (!seen) $display("FAIL arst_reach_capt: got st=%0d want 4", state); else n_pass++;
      rst_n = 1'b0;
      #1;
      n_chk++;
      if ({opcode, a, b, execute, result, result_valid, state} !== 19'd0)
         $display("FAIL arst_outputs: got %h want 0", {opcode, a, b, execute, result, result_valid, state});
      else n_pass++;
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (20) tick();
      n_chk++;
      if (state !== 3'd0 || opcode !== 3'd0) $display("FAIL arst_held_btn: got st=%0d op=%b want 0 0", state, opcode); else n_pass++;
      btn_enter = 1'b0;
      repeat (DB + 8) tick();
      press(1'b0, 3'b101, mv);
      n_chk++;
      if (state !== 3'd1 || opcode !== 3'b101) $display("FAIL arst_rearm: got st=%0d op=%b want 1 101", state, opcode); else n_pass++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_basic();
      test_bounce();
      test_clear_mid_entry();
      test_clear_enter_same();
      test_ignore_enter();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
